// File: rtl/probabilistic_counter_arbiter.sv
// probabilistic_counter_arbiter
//
// Shared table of ENTRIES probabilistic saturating counters. Several clients
// update it through valid/ready handshakes. A round-robin arbiter grants at
// most one update per cycle. A Galois LFSR supplies the random number that
// decides whether a counter may step into one of its two end values. A
// sweep FSM clears the whole table, one entry per cycle.
//
// Optional feature: PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
//   When it is defined, the random number comes from the random_number
//   input, and the internal LFSR and its parameters are removed.
//
// Ports:
//   clock, resetn       clock; asynchronous active-low reset
//   request_valid       per-client update request
//   request_ready       per-client grant (one-hot or zero, combinational)
//   request_index       per-client target entry; client i owns
//                       [i*INDEX_WIDTH +: INDEX_WIDTH]
//   request_increment   per-client increment request
//   request_decrement   per-client decrement request
//   read_index          read port address
//   read_count          table[read_index] before the edge; 0 when out of range
//   clear_start         pulse that starts a table clear
//   clear_busy          high while the clear sweep runs
//   random_number       (optional) external random number
module probabilistic_counter_arbiter #(
  parameter int REQUESTERS           = 2,
  parameter int ENTRIES              = 16,
  parameter int RANGE                = 4,
  parameter int RESET_VALUE          = 0,
  parameter int RANDOM_NUMBER_WIDTH  = 8,
  parameter int SATURATION_THRESHOLD = 64,
`ifndef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
  parameter logic [RANDOM_NUMBER_WIDTH-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [RANDOM_NUMBER_WIDTH-1:0] LFSR_SEED = 8'h01,
`endif
  parameter int INDEX_WIDTH          = $clog2(ENTRIES),
  parameter int WIDTH                = $clog2(RANGE)
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [REQUESTERS-1:0]             request_valid,
  output logic [REQUESTERS-1:0]             request_ready,
  input  logic [REQUESTERS*INDEX_WIDTH-1:0] request_index,
  input  logic [REQUESTERS-1:0]             request_increment,
  input  logic [REQUESTERS-1:0]             request_decrement,
  input  logic [INDEX_WIDTH-1:0]            read_index,
  output logic [WIDTH-1:0]                  read_count,
  input  logic                              clear_start,
  output logic                              clear_busy
`ifdef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
  ,
  input  logic [RANDOM_NUMBER_WIDTH-1:0]    random_number
`endif
);

  localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX      = WIDTH'(RANGE - 1);
  localparam logic [WIDTH-1:0] CNT_NEAR_MAX = WIDTH'(RANGE - 2);
  localparam logic [WIDTH-1:0] CNT_ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_RST      = WIDTH'(RESET_VALUE);
  localparam logic [RANDOM_NUMBER_WIDTH:0] SAT_THR =
    (RANDOM_NUMBER_WIDTH + 1)'(SATURATION_THRESHOLD);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(ENTRIES - 1);
  localparam logic [PTR_W-1:0]       LAST_PTR   = PTR_W'(REQUESTERS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic                     clear_busy_q, clear_busy_d;
  logic [INDEX_WIDTH-1:0]   clear_index_q, clear_index_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]         table_q [ENTRIES];
  logic [WIDTH-1:0]         table_d [ENTRIES];

  logic [REQUESTERS-1:0]    grant_s;
  logic [PTR_W-1:0]         grant_idx_s;
  logic                     handshake_s;
  int                       cand_s;
  logic [INDEX_WIDTH-1:0]   sel_index_s;
  logic                     sel_inc_s;
  logic                     sel_dec_s;
  logic                     sel_in_range_s;
  logic [WIDTH-1:0]         cur_cnt_s;
  logic [WIDTH-1:0]         next_cnt_s;
  logic [RANDOM_NUMBER_WIDTH-1:0] rnd_s;
  logic                     rand_ok_s;

`ifdef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
  assign rnd_s = random_number;
`else
  logic [RANDOM_NUMBER_WIDTH-1:0] lfsr_q, lfsr_d;
  assign rnd_s = lfsr_q;

  // LFSR steps only when an update is accepted, so it stays frozen while the table is idle or clearing
  always_comb begin
    lfsr_d = lfsr_q;
    if (handshake_s) begin
      if (lfsr_q[0]) begin
        lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
      end else begin
        lfsr_d = lfsr_q >> 1;
      end
    end else begin
      lfsr_d = lfsr_q;
    end
  end
`endif

  assign rand_ok_s = ({1'b0, rnd_s} < SAT_THR);

  // Round-robin search: the first valid client at or after the pointer wins; nothing is granted while clearing or on the clear_start cycle
  always_comb begin
    grant_s     = {REQUESTERS{1'b0}};
    grant_idx_s = {PTR_W{1'b0}};
    handshake_s = 1'b0;
    cand_s      = 0;
    if ((state_q == ST_IDLE) && !clear_start) begin
      for (int i = 0; i < REQUESTERS; i++) begin
        cand_s = (int'(ptr_q) + i) % REQUESTERS;
        if (!handshake_s && request_valid[cand_s]) begin
          handshake_s = 1'b1;
          grant_idx_s = PTR_W'(cand_s);
        end else begin
          handshake_s = handshake_s;
        end
      end
      if (handshake_s) begin
        grant_s[grant_idx_s] = 1'b1;
      end else begin
        grant_s = {REQUESTERS{1'b0}};
      end
    end else begin
      grant_s = {REQUESTERS{1'b0}};
    end
  end

  // New value for the granted entry: steps into 0 or RANGE-1 are taken only when the random number is below the threshold
  always_comb begin
    sel_index_s    = request_index[int'(grant_idx_s)*INDEX_WIDTH +: INDEX_WIDTH];
    sel_inc_s      = request_increment[grant_idx_s];
    sel_dec_s      = request_decrement[grant_idx_s];
    sel_in_range_s = (int'(sel_index_s) < ENTRIES);
    cur_cnt_s      = {WIDTH{1'b0}};
    if (sel_in_range_s) begin
      cur_cnt_s = table_q[sel_index_s];
    end else begin
      cur_cnt_s = {WIDTH{1'b0}};
    end
    next_cnt_s = cur_cnt_s;
    if (sel_inc_s && !sel_dec_s) begin
      if ((cur_cnt_s != CNT_MAX) && ((cur_cnt_s != CNT_NEAR_MAX) || rand_ok_s)) begin
        next_cnt_s = cur_cnt_s + CNT_ONE;
      end else begin
        next_cnt_s = cur_cnt_s;
      end
    end else if (sel_dec_s && !sel_inc_s) begin
      if ((cur_cnt_s != {WIDTH{1'b0}}) && ((cur_cnt_s != CNT_ONE) || rand_ok_s)) begin
        next_cnt_s = cur_cnt_s - CNT_ONE;
      end else begin
        next_cnt_s = cur_cnt_s;
      end
    end else begin
      next_cnt_s = cur_cnt_s;
    end
  end

  // Next state: the IDLE/CLEAR sweep, the arbitration pointer and the table write
  always_comb begin
    state_d       = state_q;
    clear_busy_d  = clear_busy_q;
    clear_index_d = clear_index_q;
    ptr_d         = ptr_q;
    table_d       = table_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d       = ST_CLEAR;
          clear_busy_d  = 1'b1;
          clear_index_d = {INDEX_WIDTH{1'b0}};
        end else if (handshake_s) begin
          if (grant_idx_s == LAST_PTR) begin
            ptr_d = {PTR_W{1'b0}};
          end else begin
            ptr_d = grant_idx_s + PTR_W'(1);
          end
          if (sel_in_range_s) begin
            table_d[sel_index_s] = next_cnt_s;
          end else begin
            table_d = table_q;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_CLEAR: begin
        table_d[clear_index_q] = CNT_RST;
        if (clear_index_q == LAST_INDEX) begin
          state_d      = ST_IDLE;
          clear_busy_d = 1'b0;
        end else begin
          clear_index_d = clear_index_q + INDEX_WIDTH'(1);
        end
      end
      default: begin
        state_d      = ST_IDLE;
        clear_busy_d = 1'b0;
      end
    endcase
  end

  // State registers and the counter table; reset puts every entry back to RESET_VALUE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      clear_busy_q  <= 1'b0;
      clear_index_q <= {INDEX_WIDTH{1'b0}};
      ptr_q         <= {PTR_W{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= CNT_RST;
      end
`ifndef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
      lfsr_q        <= LFSR_SEED;
`endif
    end else begin
      state_q       <= state_d;
      clear_busy_q  <= clear_busy_d;
      clear_index_q <= clear_index_d;
      ptr_q         <= ptr_d;
      table_q       <= table_d;
`ifndef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
      lfsr_q        <= lfsr_d;
`endif
    end
  end

  // Read port shows the value before the edge; addresses past the table read as zero
  always_comb begin
    read_count = {WIDTH{1'b0}};
    if (int'(read_index) < ENTRIES) begin
      read_count = table_q[read_index];
    end else begin
      read_count = {WIDTH{1'b0}};
    end
  end

  assign request_ready = grant_s;
  assign clear_busy    = clear_busy_q;

endmodule

// File: tb/tb_probabilistic_counter_arbiter.sv
// Self-checking bench for probabilistic_counter_arbiter (default parameters).
// A reference model tracks the table, pointer, random source and clear
// sweep. Each accepted update pushes the expected entry value to a queue.
// The value is popped and compared with read_count one cycle later.
module tb_probabilistic_counter_arbiter;

  localparam int R    = 2;
  localparam int E    = 16;
  localparam int RG   = 4;
  localparam int IW   = 4;
  localparam int W    = 2;
  localparam int RW   = 8;
  localparam int THR  = 64;
  localparam int RV   = 0;
  localparam logic [RW-1:0] TAPS = 8'hB8;
  localparam logic [RW-1:0] SEED = 8'h01;

  logic              clock = 1'b0;
  logic              resetn;
  logic [R-1:0]      request_valid;
  logic [R-1:0]      request_ready;
  logic [R*IW-1:0]   request_index;
  logic [R-1:0]      request_increment;
  logic [R-1:0]      request_decrement;
  logic [IW-1:0]     read_index;
  logic [W-1:0]      read_count;
  logic              clear_start;
  logic              clear_busy;
`ifdef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
  logic [RW-1:0]     random_number;
`endif

  always #5 clock = ~clock;

  probabilistic_counter_arbiter dut (
    .clock             (clock),
    .resetn            (resetn),
    .request_valid     (request_valid),
    .request_ready     (request_ready),
    .request_index     (request_index),
    .request_increment (request_increment),
    .request_decrement (request_decrement),
    .read_index        (read_index),
    .read_count        (read_count),
    .clear_start       (clear_start),
    .clear_busy        (clear_busy)
`ifdef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
    ,
    .random_number     (random_number)
`endif
  );

  int            n_checks = 0;
  int            n_errors = 0;
  int            m_tab [E];
  logic [RW-1:0] m_lfsr;
  int            m_ptr;
  bit            m_busy;
  int            m_cidx;
  int            exp_q [$];
  int            cyc = 0;
  int            last_hs_client = -1;
  int            last_hs_cyc = -1;
  int            busy_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < E; i++) m_tab[i] = RV;
    m_lfsr = SEED;
    m_ptr  = 0;
    m_busy = 1'b0;
    m_cidx = 0;
    exp_q.delete();
  endtask

  function automatic int model_rand();
`ifdef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
    return int'(random_number);
`else
    return int'(m_lfsr);
`endif
  endfunction

  task automatic set_req(input int c, input bit v, input int idx, input bit inc, input bit dec);
    request_valid[c]               = v;
    request_index[c*IW +: IW]      = IW'(idx);
    request_increment[c]           = inc;
    request_decrement[c]           = dec;
  endtask

  // One clock cycle: called just after a negedge once the inputs are driven.
  task automatic step();
    int g;
    int idx;
    int c;
    int r;
    bit inc;
    bit dec;
    logic [R-1:0] exp_rdy;
    #1;
    if (exp_q.size() > 0) check_eq("read_after_update", read_count, exp_q.pop_front());
    check_eq("clear_busy", clear_busy, m_busy);
    g = -1;
    exp_rdy = '0;
    if (!m_busy && !clear_start) begin
      for (int i = 0; i < R; i++) begin
        idx = (m_ptr + i) % R;
        if (g < 0 && request_valid[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("request_ready", request_ready, exp_rdy);
    if (g >= 0) begin
      idx = int'(request_index[g*IW +: IW]);
      inc = request_increment[g];
      dec = request_decrement[g];
      r   = model_rand();
      if (idx < E) begin
        c = m_tab[idx];
        if (inc && !dec && c != RG-1) begin
          if (c != RG-2 || r < THR) c = c + 1;
        end else if (dec && !inc && c != 0) begin
          if (c != 1 || r < THR) c = c - 1;
        end
        m_tab[idx] = c;
        read_index = IW'(idx);
        exp_q.push_back(c);
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
      m_ptr = (g + 1) % R;
      last_hs_client = g;
      last_hs_cyc = cyc;
    end
    if (m_busy) begin
      busy_cycles++;
      m_tab[m_cidx] = RV;
      if (m_cidx == E-1) m_busy = 1'b0;
      else m_cidx++;
    end else if (clear_start) begin
      m_busy = 1'b1;
      m_cidx = 0;
    end
    cyc++;
    @(negedge clock);
  endtask

  // Compare every entry with the model; only used while the table is quiet.
  task automatic read_sweep(input string tag);
    for (int i = 0; i < E; i++) begin
      read_index = IW'(i);
      #1;
      check_eq(tag, read_count, m_tab[i]);
    end
    @(negedge clock);
  endtask

  task automatic idle_all();
    for (int c = 0; c < R; c++) set_req(c, 1'b0, 0, 1'b0, 1'b0);
    clear_start = 1'b0;
  endtask

  int fall_cyc;

  initial begin
    resetn = 1'b0;
    request_valid = '0;
    request_index = '0;
    request_increment = '0;
    request_decrement = '0;
    read_index = '0;
    clear_start = 1'b0;
`ifdef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
    random_number = '0;
`endif
    model_reset();

    // Reset state
    #2;
    check_eq("reset_clear_busy", clear_busy, 1'b0);
    check_eq("reset_ready", request_ready, 0);
    read_sweep("reset_read");
    resetn = 1'b1;

    // Client 0 increments entry 3 repeatedly, crossing the gated step into RANGE-1
    set_req(0, 1'b1, 3, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    // Client 1 walks entry 3 back down through the gated step into 0
    set_req(0, 1'b0, 0, 1'b0, 1'b0);
    set_req(1, 1'b1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step();
    idle_all();
    step();

    // Both clients continuously valid on different entries: grants alternate
    set_req(0, 1'b1, 5, 1'b1, 1'b0);
    set_req(1, 1'b1, 9, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step();
    idle_all();
    step();

    // Increment and decrement together on entry 7 after bringing it up
    set_req(0, 1'b1, 7, 1'b1, 1'b0);
    step();
    set_req(0, 1'b1, 7, 1'b1, 1'b1);
    step();
    step();
    idle_all();
    step();
    read_sweep("after_directed");

    // Clear with a request held during the whole sweep
    clear_start = 1'b1;
    set_req(1, 1'b1, 9, 1'b0, 1'b1);
    step();
    clear_start = 1'b0;
    busy_cycles = 0;
    fall_cyc = -1;
    for (int i = 0; i < 24 && fall_cyc < 0; i++) begin
      if (!m_busy) fall_cyc = cyc;
      else step();
    end
    check_eq("clear_busy_cycles", busy_cycles, E);
    step();
    check_eq("held_req_after_clear", last_hs_cyc, fall_cyc);
    idle_all();
    step();
    read_sweep("after_clear");

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < R; c++) begin
        if (!request_valid[c] && ($urandom_range(1, 0) == 1))
          set_req(c, 1'b1, $urandom_range(E-1, 0), 1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)));
      end
      clear_start = ($urandom_range(59, 0) == 0);
`ifdef PROBABILISTIC_COUNTER_ARBITER_EXTERNAL_RANDOM_EN
      random_number = RW'($urandom_range(255, 0));
`endif
      step();
      if (last_hs_cyc == cyc - 1) request_valid[last_hs_client] = 1'b0;
    end
    idle_all();
    for (int i = 0; i < E + 2; i++) step();
    read_sweep("after_random");

    // Reset in the middle of a sweep
    set_req(0, 1'b1, 2, 1'b1, 1'b0);
    step();
    step();
    idle_all();
    step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    resetn = 1'b0;
    model_reset();
    #1;
    check_eq("midclear_reset_busy", clear_busy, 1'b0);
    read_sweep("midclear_reset_read");
    resetn = 1'b1;
    set_req(1, 1'b1, 4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    idle_all();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
